wb_writer: RTL and testbench



---
 rtl/wb_writer.sv | 127 ++++++++++++
 tb/tb_wb_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// Writeback driver: merges the load channel and a FIFO-buffered ALU channel into one registered register-file write.
// Optional WB_WRITER_FWD_EN adds same-edge read/write forwarding outputs for the two decode read ports.
module wb_writer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_type,
`ifdef WB_WRITER_FWD_EN
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
  output logic [31:0] fwd_a_data,
  output logic [31:0] fwd_b_data,
`endif
  output logic        regwrite,
  output logic [4:0]  rd,
  output logic [31:0] writedata,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign fifo_empty = (count == '0);
  assign alu_ready  = rst_n & (count != FULL);
  assign accept     = alu_valid & alu_ready;
  // An accepted beat only skips the FIFO when nothing else owns the write port this cycle.
  assign push       = accept & (ld_valid | ~fifo_empty);
  assign pop        = ~ld_valid & ~fifo_empty;
  assign busy       = ~fifo_empty | regwrite;

  always_comb begin
    ld_byte = 8'h00;
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_type)
      3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_fmt = {16'h0000, ld_half};
      3'd3:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_fmt = {24'h000000, ld_byte};
      default: ld_fmt = ld_word;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      regwrite  <= 1'b0;
      rd        <= 5'd0;
      writedata <= 32'h0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ld_valid) begin
        regwrite  <= (ld_rd != 5'd0);
        rd        <= ld_rd;
        writedata <= ld_fmt;
      end else if (!fifo_empty) begin
        regwrite  <= (fifo_rd[rd_ptr] != 5'd0);
        rd        <= fifo_rd[rd_ptr];
        writedata <= fifo_data[rd_ptr];
      end else if (accept) begin
        regwrite  <= (alu_rd != 5'd0);
        rd        <= alu_rd;
        writedata <= alu_data;
      end else begin
        regwrite  <= 1'b0;
      end
    end
  end

`ifdef WB_WRITER_FWD_EN
  // The register file returns the old value on a same-edge read, so bypass the in-flight write.
  assign fwd_a_hit  = regwrite & (rd != 5'd0) & (rd == rs);
  assign fwd_b_hit  = regwrite & (rd != 5'd0) & (rd == rt);
  assign fwd_a_data = fwd_a_hit ? writedata : 32'h0;
  assign fwd_b_data = fwd_b_hit ? writedata : 32'h0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: a reference model predicts each register-file write as stimulus is driven.
// Define WB_WRITER_FWD_EN to also exercise the forwarding ports.
module tb_wb_writer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'h0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [31:0] ld_word = 32'h0;
  logic [1:0]  ld_off = 2'd0;
  logic [2:0]  ld_type = 3'd0;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        busy;
`ifdef WB_WRITER_FWD_EN
  logic [4:0]  rs = 5'd0;
  logic [4:0]  rt = 5'd0;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_a_data;
  logic [31:0] fwd_b_data;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t model_q[$];

  wb_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_word(ld_word), .ld_off(ld_off), .ld_type(ld_type),
`ifdef WB_WRITER_FWD_EN
    .rs(rs), .rt(rt), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
`endif
    .regwrite(regwrite), .rd(rd), .writedata(writedata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] typ);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (typ)
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      default: return w;
    endcase
  endfunction

  // Every committed write is popped from the scoreboard in order.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && regwrite) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write rd=%0d data=%h, expected no write", rd, writedata);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e.rd || writedata !== e.data) begin
          n_fail++;
          $display("FAIL wb_write got rd=%0d data=%h, expected rd=%0d data=%h", rd, writedata, e.rd, e.data);
        end
      end
    end
  end

  // Applies one cycle of stimulus and advances the reference model; returns at posedge+1.
  task automatic drive(input logic ldv, input logic [4:0] lrd, input logic [31:0] lw,
                       input logic [1:0] lo, input logic [2:0] lt,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       output logic acc);
    wr_t e;
    acc = av && (model_q.size() != DEPTH);
    ld_valid = ldv; ld_rd = lrd; ld_word = lw; ld_off = lo; ld_type = lt;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    if (ldv) begin
      if (lrd != 5'd0) exp_q.push_back({lrd, fmt(lw, lo, lt)});
      if (acc) model_q.push_back({ard, ad});
    end else if (model_q.size() != 0) begin
      e = model_q.pop_front();
      if (e.rd != 5'd0) exp_q.push_back(e);
      if (acc) model_q.push_back({ard, ad});
    end else if (acc && ard != 5'd0) begin
      exp_q.push_back({ard, ad});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    logic acc;
    drive(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 1'b0, 5'd0, 32'h0, acc);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (regwrite !== 1'b0 || rd !== 5'd0 || writedata !== 32'h0 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got we=%b rd=%0d data=%h ready=%b, expected 0/0/0/0", regwrite, rd, writedata, alu_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (alu_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got ready=%b busy=%b, expected 1/0", alu_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    logic acc;
    drive(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 5'd5, 32'h1234, acc);
    n_cmp++;
    if (regwrite !== 1'b1 || rd !== 5'd5 || writedata !== 32'h00001234) begin
      n_fail++;
      $display("FAIL bypass got we=%b rd=%0d data=%h, expected 1/5/00001234", regwrite, rd, writedata);
    end
    idle();
    n_cmp++;
    if (regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_end got we=%b, expected 0", regwrite);
    end
  endtask

  task automatic test_collision();
    logic acc;
    drive(1'b1, 5'd7, 32'h80FF0011, 2'd3, 3'd3, 1'b1, 5'd9, 32'hA, acc);
    n_cmp++;
    if (rd !== 5'd7 || writedata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL collision_load got rd=%0d data=%h, expected 7/ffffff80", rd, writedata);
    end
    idle();
    n_cmp++;
    if (rd !== 5'd9 || writedata !== 32'h0000000A || regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_alu got we=%b rd=%0d data=%h, expected 1/9/0000000a", regwrite, rd, writedata);
    end
    idle();
  endtask

  typedef struct packed {
    logic [2:0]  t;
    logic [1:0]  o;
    logic [31:0] e;
  } ld_case_t;

  task automatic test_load_format();
    logic acc;
    ld_case_t tab[13] = '{
      '{3'd2, 2'd2, 32'h00008001}, '{3'd1, 2'd0, 32'h00007FFF}, '{3'd1, 2'd2, 32'hFFFF8001},
      '{3'd1, 2'd3, 32'hFFFF8001}, '{3'd2, 2'd1, 32'h00007FFF}, '{3'd3, 2'd1, 32'h0000007F},
      '{3'd3, 2'd3, 32'hFFFFFF80}, '{3'd4, 2'd3, 32'h00000080}, '{3'd4, 2'd0, 32'h000000FF},
      '{3'd3, 2'd0, 32'hFFFFFFFF}, '{3'd0, 2'd1, 32'h80017FFF}, '{3'd6, 2'd2, 32'h80017FFF},
      '{3'd3, 2'd2, 32'h00000001}};
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 5'(i + 1), 32'h80017FFF, tab[i].o, tab[i].t, 1'b0, 5'd0, 32'h0, acc);
      n_cmp++;
      if (writedata !== tab[i].e) begin
        n_fail++;
        $display("FAIL load_fmt[%0d] type=%0d off=%0d got %h, expected %h", i, tab[i].t, tab[i].o, writedata, tab[i].e);
      end
    end
    idle();
  endtask

  task automatic test_fifo_full();
    logic acc;
    int idx = 0;
    logic [4:0]  ard[3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] ad[3]  = '{32'h101, 32'h102, 32'h103};
    logic        exp_ready[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  exp_rd[6]    = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd1, 5'd2};
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (alu_ready !== exp_ready[c]) begin
        n_fail++;
        $display("FAIL fifo_ready[%0d] got %b, expected %b", c, alu_ready, exp_ready[c]);
      end
      drive(c < 4, 5'(20 + c), 32'h1000 + c, 2'd0, 3'd0, idx < 3, ard[idx < 3 ? idx : 2], ad[idx < 3 ? idx : 2], acc);
      if (acc) idx++;
      n_cmp++;
      if (rd !== exp_rd[c] || regwrite !== 1'b1) begin
        n_fail++;
        $display("FAIL fifo_order[%0d] got we=%b rd=%0d, expected 1/%0d", c, regwrite, rd, exp_rd[c]);
      end
    end
    idle();
    n_cmp++;
    if (rd !== 5'd3 || writedata !== 32'h103 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fifo_last got rd=%0d data=%h busy=%b, expected 3/00000103/1", rd, writedata, busy);
    end
    idle();
  endtask

  task automatic test_rd_zero();
    logic acc;
    drive(1'b1, 5'd13, 32'h13, 2'd0, 3'd0, 1'b1, 5'd0, 32'h55, acc);
    idle();
    n_cmp++;
    if (regwrite !== 1'b0 || rd !== 5'd0 || writedata !== 32'h55) begin
      n_fail++;
      $display("FAIL rd0_alu got we=%b rd=%0d data=%h, expected 0/0/00000055", regwrite, rd, writedata);
    end
    drive(1'b1, 5'd0, 32'h000000AB, 2'd0, 3'd4, 1'b0, 5'd0, 32'h0, acc);
    n_cmp++;
    if (regwrite !== 1'b0 || rd !== 5'd0 || writedata !== 32'hAB || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_load got we=%b rd=%0d data=%h busy=%b, expected 0/0/000000ab/0", regwrite, rd, writedata, busy);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    logic acc;
    drive(1'b1, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 5'd11, 32'hB, acc);
    drive(1'b1, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 5'd12, 32'hC, acc);
    rst_n = 1'b0;
    model_q.delete();
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || regwrite !== 1'b0 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got busy=%b we=%b ready=%b, expected 0/0/0", busy, regwrite, alu_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drain got busy=%b, expected 0", busy);
    end
  endtask

`ifdef WB_WRITER_FWD_EN
  task automatic test_fwd();
    logic acc;
    drive(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 5'd4, 32'hDEAD, acc);
    rs = 5'd4; rt = 5'd0;
    #1;
    n_cmp++;
    if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'hDEAD || fwd_b_hit !== 1'b0 || fwd_b_data !== 32'h0) begin
      n_fail++;
      $display("FAIL fwd_hit got a=%b/%h b=%b/%h, expected 1/0000dead 0/00000000", fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data);
    end
    drive(1'b0, 5'd0, 32'h0, 2'd0, 3'd0, 1'b1, 5'd0, 32'h1, acc);
    rs = 5'd0; rt = 5'd0;
    #1;
    n_cmp++;
    if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_a_data !== 32'h0) begin
      n_fail++;
      $display("FAIL fwd_rd0 got a=%b b=%b data=%h, expected 0/0/00000000", fwd_a_hit, fwd_b_hit, fwd_a_data);
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_load_format();
    test_fifo_full();
    test_rd_zero();
    test_mid_reset();
`ifdef WB_WRITER_FWD_EN
    test_fwd();
`endif
    for (int i = 0; i < 3; i++) idle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending writes, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
